// File: rtl/matrix_ula_if.sv
// matrix_ula_if
// Bundles the start/done handshake and the matrix operand/result buses of
// matrix_ula.
//   master : the requester drives start, opcode, data_escalar, matrizA and
//            matrizB, and observes the result and status flags.
//   slave  : matrix_ula drives matriz_resultante, done, busy, overflow and err.
// Element (r,c) of a matrix bus sits at bits [((r*N)+c)*W +: W].
interface matrix_ula_if #(
    parameter int N = 5,
    parameter int W = 8
);
    localparam int MW = N * N * W;

    logic                  start;
    logic [3:0]            opcode;
    logic signed [W-1:0]   data_escalar;
    logic [MW-1:0]         matrizA;
    logic [MW-1:0]         matrizB;
    logic [MW-1:0]         matriz_resultante;
    logic                  done;
    logic                  busy;
    logic                  overflow;
    logic                  err;

    modport master (
        output start, opcode, data_escalar, matrizA, matrizB,
        input  matriz_resultante, done, busy, overflow, err
    );

    modport slave (
        input  start, opcode, data_escalar, matrizA, matrizB,
        output matriz_resultante, done, busy, overflow, err
    );
endinterface

// File: rtl/matrix_ula.sv
// matrix_ula
// NxN matrix ALU on W-bit two's-complement elements. Supports transpose,
// negate, add, subtract, scalar multiply (single cycle) and matrix product
// (one result row per cycle). Results wrap to W bits; overflow flags any
// element whose exact value did not fit.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : matrix_ula_if slave modport (start/opcode/data_escalar/matrizA/
//            matrizB in; matriz_resultante/done/busy/overflow/err out)
module matrix_ula #(
    parameter int N = 5,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    matrix_ula_if.slave  bus
);
    localparam int MW = N * N * W;
    localparam int RW = $clog2(N);
    // Wide enough for any exact intermediate, including an N-term dot product.
    localparam int AW = 2 * W + $clog2(N) + 1;
    localparam logic [RW-1:0] LAST_ROW = RW'(N - 1);

    typedef enum logic [1:0] {IDLE, LOAD, EXEC, DONE} state_t;

    state_t               state;
    logic [RW-1:0]        row_q;
    logic [3:0]           op_q;
    logic signed [W-1:0]  k_q;
    logic [MW-1:0]        a_q;
    logic [MW-1:0]        b_q;
    logic [MW-1:0]        result_q;
    logic                 done_q;
    logic                 busy_q;
    logic                 ovf_q;
    logic                 err_q;

    logic [MW-1:0]        res_full;
    logic                 ovf_full;
    logic [N*W-1:0]       row_res;
    logic                 row_ovf;
    logic                 legal;

    // Element (r,c) of a matrix bus, sign-extended to the working width.
    function automatic logic signed [AW-1:0] el(input logic [MW-1:0] m,
                                                 input int r, input int c);
        logic signed [W-1:0] e;
        e = m[((r * N) + c) * W +: W];
        return AW'(e);
    endfunction

    // Low W bits of the exact value: results wrap.
    function automatic logic [W-1:0] wrap(input logic signed [AW-1:0] v);
        return v[W-1:0];
    endfunction

    // Value fits in W signed bits iff all bits from W-1 upward equal the sign.
    function automatic logic fits(input logic signed [AW-1:0] v);
        logic [AW-W:0] top;
        top = v[AW-1:W-1];
        return (top == '0) || (top == '1);
    endfunction

    assign legal = (op_q >= 4'd1) && (op_q <= 4'd6);

    // Element-wise ops: whole result in one cycle.
    always_comb begin : full_calc
        logic signed [AW-1:0] v;
        res_full = '0;
        ovf_full = 1'b0;
        v        = '0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                case (op_q)
                    4'd1:    v = el(a_q, c, r);
                    4'd2:    v = -el(a_q, r, c);
                    4'd3:    v = el(a_q, r, c) + el(b_q, r, c);
                    4'd4:    v = el(a_q, r, c) - el(b_q, r, c);
                    4'd5:    v = AW'(k_q) * el(a_q, r, c);
                    default: v = '0;
                endcase
                res_full[((r * N) + c) * W +: W] = wrap(v);
                if (!fits(v)) ovf_full = 1'b1;
            end
        end
    end

    // Matrix product: one row of dot products for the current row counter.
    always_comb begin : row_calc
        logic signed [AW-1:0] acc;
        row_res = '0;
        row_ovf = 1'b0;
        acc     = '0;
        for (int c = 0; c < N; c++) begin
            acc = '0;
            for (int k = 0; k < N; k++) begin
                acc = acc + el(a_q, int'(row_q), k) * el(b_q, k, c);
            end
            row_res[c * W +: W] = wrap(acc);
            if (!fits(acc)) row_ovf = 1'b1;
        end
    end

    // Operand capture: only loaded on the accepting edge, so later input
    // changes cannot disturb an op in flight.
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.start && !done_q) begin
            a_q  <= bus.matrizA;
            b_q  <= bus.matrizB;
            k_q  <= bus.data_escalar;
            op_q <= bus.opcode;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            row_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start && !done_q) begin
                        busy_q <= 1'b1;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    ovf_q <= 1'b0;
                    err_q <= 1'b0;
                    row_q <= '0;
                    state <= EXEC;
                end
                EXEC: begin
                    if (!legal) begin
                        err_q  <= 1'b1;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else if (op_q == 4'd6) begin
                        // Rows beyond row_q keep their previous contents.
                        result_q[int'(row_q) * N * W +: N * W] <= row_res;
                        if (row_ovf) ovf_q <= 1'b1;
                        if (row_q == LAST_ROW) begin
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= DONE;
                        end else begin
                            row_q <= row_q + 1'b1;
                        end
                    end else begin
                        result_q <= res_full;
                        ovf_q    <= ovf_full;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    // Wait for start to drop so a held request is not re-run.
                    if (!bus.start) begin
                        done_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.matriz_resultante = result_q;
    assign bus.done              = done_q;
    assign bus.busy              = busy_q;
    assign bus.overflow          = ovf_q;
    assign bus.err               = err_q;
endmodule

// File: tb/tb_matrix_ula.sv
module tb_matrix_ula;
    localparam int N  = 5;
    localparam int W  = 8;
    localparam int MW = N * N * W;

    logic clk;
    logic rst_n;

    matrix_ula_if #(.N(N), .W(W)) bus ();

    matrix_ula #(.N(N), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]    op;
        logic [7:0]    k;
        logic [MW-1:0] a;
        logic [MW-1:0] b;
        logic [MW-1:0] exp_r;
        logic          exp_ovf;
        logic          exp_err;
        int            exp_lat;
        logic          early;
    } vec_t;

    vec_t vec [9];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [MW-1:0] fill(input logic [7:0] v);
        logic [MW-1:0] m;
        m = '0;
        for (int i = 0; i < N * N; i++) m[i * W +: W] = v;
        return m;
    endfunction

    function automatic logic [MW-1:0] ramp();
        logic [MW-1:0] m;
        m = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) m[(r * N + c) * W +: W] = 8'(r * 5 + c);
        return m;
    endfunction

    function automatic logic [MW-1:0] tramp();
        logic [MW-1:0] m;
        m = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) m[(r * N + c) * W +: W] = 8'(c * 5 + r);
        return m;
    endfunction

    function automatic logic [MW-1:0] ident();
        logic [MW-1:0] m;
        m = '0;
        for (int r = 0; r < N; r++) m[(r * N + r) * W +: W] = 8'h01;
        return m;
    endfunction

    task automatic chk(input string nm, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input int i);
        int edges;
        @(negedge clk);
        bus.opcode       = vec[i].op;
        bus.data_escalar = vec[i].k;
        bus.matrizA      = vec[i].a;
        bus.matrizB      = vec[i].b;
        bus.start        = 1'b1;
        @(posedge clk);
        #1;
        // Scramble inputs after acceptance; the op must use the latched copies.
        bus.matrizA      = ~vec[i].a;
        bus.matrizB      = ~vec[i].b;
        bus.opcode       = 4'd2;
        bus.data_escalar = ~vec[i].k;
        if (vec[i].early) bus.start = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d_busy", i), MW'(bus.busy), MW'(1));
        edges = 0;
        while (edges < 40) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (bus.done) break;
        end
        chk($sformatf("v%0d_done", i), MW'(bus.done), MW'(1));
        chk($sformatf("v%0d_lat", i), MW'(edges), MW'(vec[i].exp_lat));
        chk($sformatf("v%0d_res", i), bus.matriz_resultante, vec[i].exp_r);
        chk($sformatf("v%0d_ovf", i), MW'(bus.overflow), MW'(vec[i].exp_ovf));
        chk($sformatf("v%0d_err", i), MW'(bus.err), MW'(vec[i].exp_err));
        chk($sformatf("v%0d_busy_end", i), MW'(bus.busy), MW'(0));
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("v%0d_done_clr", i), MW'(bus.done), MW'(0));
    endtask

    initial begin
        logic [MW-1:0] a_neg;
        logic [MW-1:0] exp_neg;
        logic [MW-1:0] exp_m;
        int            edges;

        a_neg   = fill(8'h03);
        a_neg[7:0] = 8'h80;
        exp_neg = fill(8'hFD);
        exp_neg[7:0] = 8'h80;

        vec[0] = '{4'd3, 8'h00, fill(8'd10),  fill(8'd20),  fill(8'h1E), 1'b0, 1'b0, 2, 1'b0};
        vec[1] = '{4'd4, 8'h00, fill(8'd5),   fill(8'd7),   fill(8'hFE), 1'b0, 1'b0, 2, 1'b1};
        vec[2] = '{4'd3, 8'h00, fill(8'd100), fill(8'd100), fill(8'hC8), 1'b1, 1'b0, 2, 1'b0};
        vec[3] = '{4'd6, 8'h00, ident(),      ramp(),       ramp(),      1'b0, 1'b0, 6, 1'b0};
        vec[4] = '{4'd5, 8'hFE, fill(8'd3),   fill(8'd0),   fill(8'hFA), 1'b0, 1'b0, 2, 1'b0};
        vec[5] = '{4'd2, 8'h00, a_neg,        fill(8'd0),   exp_neg,     1'b1, 1'b0, 2, 1'b0};
        vec[6] = '{4'd1, 8'h00, ramp(),       fill(8'd0),   tramp(),     1'b0, 1'b0, 2, 1'b0};
        vec[7] = '{4'd9, 8'h00, fill(8'd1),   fill(8'd1),   tramp(),     1'b0, 1'b1, 2, 1'b0};
        vec[8] = '{4'd3, 8'h00, fill(8'd0),   fill(8'd1),   fill(8'h01), 1'b0, 1'b0, 2, 1'b0};

        rst_n            = 1'b0;
        bus.start        = 1'b0;
        bus.opcode       = 4'd0;
        bus.data_escalar = '0;
        bus.matrizA      = '0;
        bus.matrizB      = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_res", bus.matriz_resultante, '0);
        chk("rst_flags", MW'({bus.done, bus.busy, bus.overflow, bus.err}), MW'(0));
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(i);

        // Product rows appear one per edge, row 0 first; later rows keep old data.
        @(negedge clk);
        bus.opcode  = 4'd6;
        bus.matrizA = ident();
        bus.matrizB = ramp();
        bus.start   = 1'b1;
        @(posedge clk);
        @(posedge clk);
        for (int j = 0; j < N; j++) begin
            @(posedge clk);
            @(negedge clk);
            exp_m = fill(8'h01);
            for (int r = 0; r <= j; r++)
                for (int c = 0; c < N; c++) exp_m[(r * N + c) * W +: W] = 8'(r * 5 + c);
            chk($sformatf("row%0d_res", j), bus.matriz_resultante, exp_m);
            chk($sformatf("row%0d_done", j), MW'(bus.done), MW'(j == N - 1));
        end
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // Async reset in the middle of a product aborts at once.
        bus.opcode  = 4'd6;
        bus.matrizA = ident();
        bus.matrizB = ramp();
        bus.start   = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        #1;
        chk("abort_res", bus.matriz_resultante, '0);
        chk("abort_flags", MW'({bus.done, bus.busy, bus.overflow, bus.err}), MW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(0);

        // Illegal op with start held high: done stays, no re-execution.
        @(negedge clk);
        bus.opcode = 4'd9;
        bus.start  = 1'b1;
        edges = 0;
        while (edges < 40) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (bus.done) break;
        end
        chk("ill_done", MW'(bus.done), MW'(1));
        chk("ill_err", MW'(bus.err), MW'(1));
        chk("ill_res", bus.matriz_resultante, fill(8'h1E));
        for (int j = 0; j < 4; j++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("hold%0d", j), MW'({bus.done, bus.busy, bus.err}), MW'(3'b101));
        end
        chk("hold_res", bus.matriz_resultante, fill(8'h1E));
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("hold_done_clr", MW'(bus.done), MW'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
